// File: rtl/cpu_seq_pkg.sv
// State codes shared by the multi-cycle sequencer and anything that decodes its state output.
package cpu_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] FETCH     = 3'd1;
    localparam logic [STATE_W-1:0] DECODE    = 3'd2;
    localparam logic [STATE_W-1:0] EXECUTE   = 3'd3;
    localparam logic [STATE_W-1:0] MEM       = 3'd4;
    localparam logic [STATE_W-1:0] WRITEBACK = 3'd5;
    localparam logic [STATE_W-1:0] HALT      = 3'd6;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous board button, followed by a one-cycle rising-edge pulse.
module edge_sync (
    input  logic clock,
    input  logic resetN,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Both terms come from flops, so the pulse is glitch-free and lasts exactly one cycle.
    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the ARM datapath: phases each instruction and gates PC, IR, register and memory strobes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | stopped, waiting for run or a step press
// FETCH     | latch instruction unless the breakpoint matches
// DECODE    | controller decodes the latched instruction
// EXECUTE   | ALU phase; branches to MEM for loads/stores
// MEM       | MEM_WAIT cycles; write strobe only on the last one
// WRITEBACK | register write, PC advance, retire count
// HALT      | halted by request, single step or breakpoint
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32,
    parameter int MEM_WAIT  = 1
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 run,
    input  logic                 step,
    input  logic                 haltReq,
    input  logic                 bpEnable,
    input  logic [PC_WIDTH-1:0]  bpAddr,
    input  logic [PC_WIDTH-1:0]  currentInst,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic                 regWrite,
    output logic                 irLoad,
    output logic                 pcEn,
    output logic                 regWriteEn,
    output logic                 memReadEn,
    output logic                 memWriteEn,
    output logic [STATE_W-1:0]   state,
    output logic                 halted,
    output logic                 bpHit,
    output logic [CNT_WIDTH-1:0] instCount
);

    localparam int                WAIT_W    = $clog2(MEM_WAIT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              one_shot;
    logic              bp_skip;
    logic              run_q;
    logic              step_edge;
    logic              bp_match;
    logic              run_rise;
    logic              mem_last;

    edge_sync u_step_sync (
        .clock  (clock),
        .resetN (resetN),
        .din    (step),
        .pulse  (step_edge)
    );

    // bp_skip lets the instruction that caused the halt execute once when resuming.
    assign bp_match = bpEnable && (currentInst == bpAddr) && !bp_skip;
    assign run_rise = run & ~run_q;
    assign mem_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            one_shot  <= 1'b0;
            bp_skip   <= 1'b0;
            bpHit     <= 1'b0;
            run_q     <= 1'b0;
            instCount <= '0;
        end else begin
            run_q <= run;
            case (state)
                IDLE: begin
                    if (haltReq) begin
                        state <= HALT;
                    end else if (run) begin
                        state <= FETCH;
                    end else if (step_edge) begin
                        state    <= FETCH;
                        one_shot <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bp_match) begin
                        state <= HALT;
                        bpHit <= 1'b1;
                    end else begin
                        state   <= DECODE;
                        bp_skip <= 1'b0;
                    end
                end
                DECODE: state <= EXECUTE;
                EXECUTE: begin
                    if (memRead || memWrite) begin
                        state    <= MEM;
                        wait_cnt <= '0;
                    end else begin
                        state <= WRITEBACK;
                    end
                end
                MEM: begin
                    if (mem_last) begin
                        state <= WRITEBACK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WRITEBACK: begin
                    instCount <= instCount + 1'b1;
                    if (haltReq || one_shot) begin
                        state    <= HALT;
                        one_shot <= 1'b0;
                    end else if (run) begin
                        state <= FETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (step_edge) begin
                        state    <= FETCH;
                        one_shot <= 1'b1;
                        bp_skip  <= 1'b1;
                        bpHit    <= 1'b0;
                    end else if (!haltReq && run_rise) begin
                        state   <= FETCH;
                        bp_skip <= 1'b1;
                        bpHit   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irLoad     = (state == FETCH) && !bp_match;
    assign pcEn       = (state == WRITEBACK);
    assign regWriteEn = (state == WRITEBACK) && regWrite;
    assign memReadEn  = (state == MEM) && memRead;
    assign memWriteEn = (state == MEM) && memWrite && mem_last;
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: a PC model plus per-instruction phase traces built from the phase rules.
module tb_cpu_sequencer;

    localparam int MW = 3;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          resetN, run, step, haltReq, bpEnable;
    logic [31:0]   bpAddr, pc;
    logic          memRead, memWrite, regWrite;
    logic          irLoad, pcEn, regWriteEn, memReadEn, memWriteEn, halted, bpHit;
    logic [2:0]    state;
    logic [CW-1:0] instCount;

    logic [2:0]    kinds [16];
    logic [9:0]    expq [$];
    logic [9:0]    obs;
    int            tests = 0;
    int            fails = 0;

    cpu_sequencer #(.PC_WIDTH(32), .CNT_WIDTH(CW), .MEM_WAIT(MW)) dut (
        .clock(clock), .resetN(resetN), .run(run), .step(step), .haltReq(haltReq),
        .bpEnable(bpEnable), .bpAddr(bpAddr), .currentInst(pc),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .irLoad(irLoad), .pcEn(pcEn), .regWriteEn(regWriteEn), .memReadEn(memReadEn),
        .memWriteEn(memWriteEn), .state(state), .halted(halted), .bpHit(bpHit),
        .instCount(instCount)
    );

    always #5 clock = ~clock;

    // Environment: PC register and controller decode looked up from a per-address table.
    always @(posedge clock) begin
        if (!resetN) pc <= 32'd0;
        else if (pcEn) pc <= pc + 32'd4;
    end
    assign memRead  = kinds[pc[5:2]][2];
    assign memWrite = kinds[pc[5:2]][1];
    assign regWrite = kinds[pc[5:2]][0];
    assign obs = {state, irLoad, pcEn, regWriteEn, memReadEn, memWriteEn, halted, bpHit};

    function automatic void push(logic [2:0] st, logic ir, logic pe, logic rw, logic mr, logic mw, logic bh);
        expq.push_back({st, ir, pe, rw, mr, mw, (st == 3'd6), bh});
    endfunction

    // Expected per-cycle view of one complete instruction.
    function automatic void push_instr(logic [2:0] k);
        push(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (k[2] || k[1])
            for (int j = 0; j < MW; j++)
                push(3'd4, 1'b0, 1'b0, 1'b0, k[2], k[1] && (j == MW - 1), 1'b0);
        push(3'd5, 1'b0, 1'b1, k[0], 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void set_kinds(int mode);
        for (int i = 0; i < 16; i++)
            case (mode)
                1:       kinds[i] = 3'b001;
                2:       kinds[i] = 3'b101;
                3:       kinds[i] = 3'b011;
                default: kinds[i] = 3'($urandom_range(0, 7));
            endcase
    endfunction

    task automatic do_reset();
        resetN = 1'b0; run = 1'b0; step = 1'b0; haltReq = 1'b0;
        bpEnable = 1'b0; bpAddr = 32'd0;
        expq.delete();
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
    endtask

    task automatic test_reset();
        set_kinds(0);
        do_reset();
        tests++;
        if (obs !== 10'b0) begin
            fails++; $display("FAIL reset_outputs got %b exp %b", obs, 10'b0);
        end
        tests++;
        if (instCount !== '0) begin
            fails++; $display("FAIL reset_count got %0d exp 0", instCount);
        end
    endtask

    task automatic test_free_run(string name, int mode, int n);
        set_kinds(mode);
        do_reset();
        for (int i = 0; i < n; i++) push_instr(kinds[i % 16]);
        run = 1'b1;
        for (int k = 0; k < expq.size(); k++) begin
            @(posedge clock); #1;
            tests++;
            if (obs !== expq[k]) begin
                fails++; $display("FAIL %s cyc %0d got %b exp %b", name, k, obs, expq[k]);
            end
        end
        run = 1'b0;
        @(posedge clock); #1;
        tests++;
        if (state !== 3'd0 || instCount !== CW'(n % 16)) begin
            fails++; $display("FAIL %s_end state %0d count %0d exp state 0 count %0d", name, state, instCount, n % 16);
        end
    endtask

    task automatic test_reset_mid_mem();
        int mem_seen = 0;
        logic saw_wr = 1'b0;
        set_kinds(3);
        do_reset();
        run = 1'b1;
        for (int c = 0; c < 20 && mem_seen < 2; c++) begin
            @(posedge clock); #1;
            if (memWriteEn) saw_wr = 1'b1;
            if (state == 3'd4) mem_seen++;
        end
        tests++;
        if (mem_seen != 2) begin
            fails++; $display("FAIL mid_mem_reach got %0d mem cycles exp 2", mem_seen);
        end
        resetN = 1'b0;
        if (memWriteEn) saw_wr = 1'b1;
        @(posedge clock); #1;
        resetN = 1'b1; run = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (memWriteEn) saw_wr = 1'b1;
            tests++;
            if (state !== 3'd0 || instCount !== '0) begin
                fails++; $display("FAIL mid_mem_reset state %0d count %0d exp 0 0", state, instCount);
            end
            @(posedge clock); #1;
        end
        tests++;
        if (saw_wr !== 1'b0) begin
            fails++; $display("FAIL mid_mem_write got memWriteEn seen %b exp 0", saw_wr);
        end
    endtask

    task automatic test_step();
        set_kinds(0);
        do_reset();
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            expq.delete();
            for (int j = 0; j < 2; j++) push((s == 0) ? 3'd0 : 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push_instr(kinds[s]);
            push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < expq.size(); k++) begin
                @(posedge clock); #1;
                tests++;
                if (obs !== expq[k]) begin
                    fails++; $display("FAIL step%0d cyc %0d got %b exp %b", s, k, obs, expq[k]);
                end
            end
            tests++;
            if (instCount !== CW'(s + 1) || pc !== 32'(4 * (s + 1))) begin
                fails++; $display("FAIL step%0d_count count %0d pc %h exp %0d %h", s, instCount, pc, s + 1, 4 * (s + 1));
            end
            step = 1'b0;
            repeat (4) @(posedge clock);
            #1;
        end
    endtask

    task automatic test_breakpoint();
        set_kinds(0);
        do_reset();
        bpEnable = 1'b1; bpAddr = 32'h0000000C;
        for (int i = 0; i < 3; i++) push_instr(kinds[i]);
        push(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run = 1'b1;
        for (int k = 0; k < expq.size(); k++) begin
            @(posedge clock); #1;
            tests++;
            if (obs !== expq[k]) begin
                fails++; $display("FAIL bp_hit cyc %0d got %b exp %b", k, obs, expq[k]);
            end
        end
        tests++;
        if (instCount !== CW'(3) || pc !== 32'hC) begin
            fails++; $display("FAIL bp_hit_pc count %0d pc %h exp 3 0000000c", instCount, pc);
        end
        step = 1'b1;
        expq.delete();
        push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_instr(kinds[3]);
        push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < expq.size(); k++) begin
            @(posedge clock); #1;
            tests++;
            if (obs !== expq[k]) begin
                fails++; $display("FAIL bp_step cyc %0d got %b exp %b", k, obs, expq[k]);
            end
        end
        tests++;
        if (instCount !== CW'(4) || pc !== 32'h10) begin
            fails++; $display("FAIL bp_step_pc count %0d pc %h exp 4 00000010", instCount, pc);
        end
        step = 1'b0; run = 1'b0;
        @(posedge clock); #1;
        run = 1'b1;
        expq.delete();
        push_instr(kinds[4]);
        for (int k = 0; k < expq.size(); k++) begin
            @(posedge clock); #1;
            tests++;
            if (obs !== expq[k]) begin
                fails++; $display("FAIL bp_resume cyc %0d got %b exp %b", k, obs, expq[k]);
            end
        end
        run = 1'b0;
        @(posedge clock); #1;
        tests++;
        if (state !== 3'd0 || instCount !== CW'(5)) begin
            fails++; $display("FAIL bp_resume_end state %0d count %0d exp 0 5", state, instCount);
        end
    endtask

    task automatic test_halt_req();
        int c = 0;
        set_kinds(1);
        do_reset();
        run = 1'b1;
        while (state !== 3'd3 && c < 10) begin
            @(posedge clock); #1;
            c++;
        end
        tests++;
        if (state !== 3'd3) begin
            fails++; $display("FAIL halt_req_reach state %0d exp 3", state);
        end
        haltReq = 1'b1;
        push(3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < expq.size(); k++) begin
            @(posedge clock); #1;
            tests++;
            if (obs !== expq[k]) begin
                fails++; $display("FAIL halt_req cyc %0d got %b exp %b", k, obs, expq[k]);
            end
        end
        tests++;
        if (instCount !== CW'(1)) begin
            fails++; $display("FAIL halt_req_count got %0d exp 1", instCount);
        end
        do_reset();
        haltReq = 1'b1; run = 1'b1;
        @(posedge clock); #1;
        tests++;
        if (state !== 3'd6 || halted !== 1'b1) begin
            fails++; $display("FAIL halt_idle state %0d halted %b exp 6 1", state, halted);
        end
        haltReq = 1'b0; run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run("alu_run", 1, 5);
        test_free_run("load_run", 2, 4);
        test_free_run("rand_run", 0, $urandom_range(10, 24));
        test_free_run("rand_run2", 0, $urandom_range(3, 9));
        test_reset_mid_mem();
        test_step();
        test_breakpoint();
        test_halt_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1);
    end

endmodule
